bsp_host_mem_wr_arbiter: RTL
============================

# bsp_host_mem_wr_arbiter

Burst-aware round-robin arbiter that shares one host-memory AVMM write channel between `NUM_REQ` write requesters, such as multiple DMA write engines or a kernel-side USM writer. It sits upstream of the host-memory IRQ/fence write mux. Each burst is forwarded intact, with the grant locked from first beat to last beat. Fence sideband is forwarded only on a burst's first beat.

## Interface
- `NUM_REQ`, 2: number of requesters; legal range 2–4.
- `ADDR_W`, 48: byte-address width.
- `DATA_W`, 512: write-data width.
- `BURST_W`, 7: burstcount width; maximum burst is 64.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_write` in `[NUM_REQ]`: per-requester write request.
- `req_address` in `[NUM_REQ][ADDR_W]`: address; sampled on the first beat only.
- `req_burstcount` in `[NUM_REQ][BURST_W]`: burst length; sampled on the first beat only.
- `req_writedata` in `[NUM_REQ][DATA_W]`: write data.
- `req_byteenable` in `[NUM_REQ][DATA_W/8]`: byte enables.
- `req_fence` in `[NUM_REQ]`: write-fence request; qualifies the first beat.
- `req_waitrequest` out `[NUM_REQ]`: per-requester backpressure.
- `wr_write` out 1: downstream write.
- `wr_address` out `ADDR_W`: downstream address.
- `wr_burstcount` out `BURST_W`: downstream burstcount.
- `wr_writedata` out `DATA_W`: downstream write data.
- `wr_byteenable` out `DATA_W/8`: downstream byte enables.
- `wr_fence` out 1: fence flag to the downstream mux.
- `wr_waitrequest` in 1: downstream backpressure.
- `grant_valid` out 1: a requester currently owns the channel.
- `grant_id` out `$clog2(NUM_REQ)`: current owner.
- `err_burst0` out 1: sticky; set when a zero burstcount is seen.

## Operation
- Beat acceptance: `acc = wr_write & !wr_waitrequest`.
- State machine: IDLE, HOLD, BURST.
- IDLE:
  - Round-robin pick among asserted `req_write`, searching from `rr_ptr`.
  - The pick is presented combinationally downstream.
  - Picked beat accepted with burstcount 1: stay in IDLE; `rr_ptr <= pick+1` (mod `NUM_REQ`).
  - Picked beat accepted with burstcount >1: go to BURST; `beats_left <= burstcount-1`.
  - Picked beat not accepted: go to HOLD; owner locked.
- HOLD:
  - Owner's first beat held until accepted; no re-arbitration.
  - On acceptance, take the same transitions as IDLE.
- BURST:
  - Owner muxed through.
  - Each `acc` decrements `beats_left`.
  - `acc` with `beats_left==1`: go to IDLE; `rr_ptr <= owner+1`.
  - Owner deasserting `req_write` mid-burst inserts bubbles only; the grant remains.
- Zero burstcount: treated as 1 and sets `err_burst0`. Only reset clears it.
- Fence: `wr_fence = req_fence[owner]` in IDLE and HOLD only; forced 0 in BURST.
- Address and burstcount are forwarded unchanged on every beat.
- Backpressure: `req_waitrequest[i] = wr_waitrequest | !(grant_valid & grant_id==i)`.
- Outputs when no grant: `wr_write=0`; data buses driven by the `rr_ptr` requester (don't-care).
- Simultaneous requests: strict round-robin; no requester waits more than `NUM_REQ-1` bursts.
- Reset mid-burst: returns to IDLE, `rr_ptr=0`, `beats_left=0`. A truncated downstream burst is the system reset's responsibility.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr=0`, `beats_left=0`, `err_burst0=0`.
  - Outputs therefore `wr_write=0`, `wr_fence=0`, `grant_valid=0`, `grant_id=0`.
- Latency: zero cycles. A requester beat appears on `wr_*` in the same cycle.
- `req_waitrequest` is combinational from `wr_waitrequest`.
- Arbitration decision: combinational in IDLE, registered into owner/state at `acc` or stall.
- Back-to-back bursts from different requesters: no idle cycle between them.
- `grant_id` is stable from first-beat presentation through last-beat acceptance.

## Structure
- Add to `ofs_asp_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD, ARB_BURST} wr_arb_state_t`.
  - `ASP_WR_ARB_NUM_REQ`.
- One sub-module, `bsp_rr_arbiter`: combinational pick from a request vector and a pointer, returning `pick_valid` and `pick_id`. Reusable for the read-channel arbiter.

## Test plan
- Both requesters write burstcount 4 simultaneously from reset, no backpressure:
  - Expect 4 beats of id0, then 4 beats of id1 with no gap.
  - `rr_ptr` returns to 0.
- id1 burst 8 with `wr_waitrequest` toggling every other cycle; id0 requests at beat 3:
  - Exactly 8 id1 beats accepted before id0's first beat.
  - `req_waitrequest[0]=1` throughout id1's burst.
- id0 first beat stalled 5 cycles (HOLD) while id1 requests:
  - `wr_address` and `grant_id` are stable for all 5 cycles.
  - id1 is served next.
- id0 first beat with `req_fence=1`, burst 3:
  - `wr_fence=1` only on beat 1; 0 on beats 2–3.
- id1 issues burstcount 0:
  - One beat forwarded; `err_burst0=1`; state returns to IDLE.
- Assert `reset` asynchronously at beat 2 of a burst-6:
  - `wr_write=0` immediately.
  - After deassertion, a new id0 burst is granted from IDLE.

Source files
------------

// File: rtl/ofs_asp_pkg.sv
// Shared types and constants for the ASP host-memory write path.
// The write arbiter state type lives here so other blocks can decode its debug port.
package ofs_asp_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HOLD,
    ARB_BURST
  } wr_arb_state_t;

  localparam int ASP_WR_ARB_NUM_REQ   = 2;
  localparam int ASP_WR_ARB_MAX_BURST = 64;

endpackage

// File: rtl/bsp_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request found searching upward
// from ptr (wrapping), reported as pick_valid / pick_id. Shared with the read arbiter.
module bsp_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               pick_valid,
  output logic [ID_W-1:0]    pick_id
);

  function automatic logic [ID_W-1:0] rot(input logic [ID_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Search from the farthest offset down so the closest request to ptr wins last.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[rot(ptr, off)]) begin
        pick_valid = 1'b1;
        pick_id    = rot(ptr, off);
      end
    end
  end

endmodule

// File: rtl/bsp_host_mem_wr_arbiter.sv
// Burst-aware round-robin arbiter sharing one host-memory AVMM write channel.
// Grant is locked first beat to last beat; fence is forwarded on first beats only.
module bsp_host_mem_wr_arbiter
  import ofs_asp_pkg::*;
#(
  parameter int NUM_REQ = ASP_WR_ARB_NUM_REQ,
  parameter int ADDR_W  = 48,
  parameter int DATA_W  = 512,
  parameter int BURST_W = 7,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                             clk,
  input  logic                             reset,

  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ-1:0][BURST_W-1:0]  req_burstcount,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_writedata,
  input  logic [NUM_REQ-1:0][BE_W-1:0]     req_byteenable,
  input  logic [NUM_REQ-1:0]               req_fence,
  output logic [NUM_REQ-1:0]               req_waitrequest,

  output logic                             wr_write,
  output logic [ADDR_W-1:0]                wr_address,
  output logic [BURST_W-1:0]               wr_burstcount,
  output logic [DATA_W-1:0]                wr_writedata,
  output logic [BE_W-1:0]                  wr_byteenable,
  output logic                             wr_fence,
  input  logic                             wr_waitrequest,

  output logic                             grant_valid,
  output logic [ID_W-1:0]                  grant_id,
  output logic                             err_burst0,

  output wr_arb_state_t                    dbg_state,
  output logic [ID_W-1:0]                  dbg_rr_ptr,
  output logic [BURST_W-1:0]               dbg_beats_left
);

  // Handshake: a beat transfers in the cycle where wr_write=1 and wr_waitrequest=0;
  // a requester beat transfers when its req_write=1 and its req_waitrequest=0, which
  // is the same cycle since the owner is muxed straight through.

  localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [BURST_W-1:0] BC_ONE  = BURST_W'(1);

  wr_arb_state_t      state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] beats_left_q, beats_left_d;
  logic               err_q, err_d;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    sel_id;
  logic               sel_active;
  logic [BURST_W-1:0] sel_bc;
  logic               acc;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  bsp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req        (req_write),
    .ptr        (rr_ptr_q),
    .pick_valid (pick_valid),
    .pick_id    (pick_id)
  );

  // Channel mux: IDLE presents the live pick, HOLD/BURST present the locked owner.
  always_comb begin
    sel_id     = owner_q;
    sel_active = 1'b1;
    if (state_q == ARB_IDLE) begin
      sel_id     = pick_valid ? pick_id : rr_ptr_q;
      sel_active = pick_valid;
    end

    // Outputs go quiet while reset is held so a cut-off burst cannot leak a beat.
    grant_valid   = sel_active & ~reset;
    grant_id      = grant_valid ? sel_id : '0;
    wr_write      = grant_valid & req_write[sel_id];
    wr_address    = req_address[sel_id];
    wr_burstcount = req_burstcount[sel_id];
    wr_writedata  = req_writedata[sel_id];
    wr_byteenable = req_byteenable[sel_id];
    wr_fence      = grant_valid & (state_q != ARB_BURST) & req_fence[sel_id];
    sel_bc        = req_burstcount[sel_id];
    acc           = wr_write & ~wr_waitrequest;

    for (int i = 0; i < NUM_REQ; i++) begin
      req_waitrequest[i] = wr_waitrequest | ~(grant_valid & (sel_id == ID_W'(i)));
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    err_d        = err_q;

    case (state_q)
      ARB_IDLE, ARB_HOLD: begin
        if (grant_valid) begin
          if (acc) begin
            // A zero burstcount is carried as a single-beat burst.
            if (sel_bc == '0) err_d = 1'b1;
            if (sel_bc > BC_ONE) begin
              state_d      = ARB_BURST;
              owner_d      = sel_id;
              beats_left_d = sel_bc - BC_ONE;
            end else begin
              state_d      = ARB_IDLE;
              beats_left_d = '0;
              rr_ptr_d     = next_id(sel_id);
            end
          end else begin
            state_d = ARB_HOLD;
            owner_d = sel_id;
          end
        end
      end

      ARB_BURST: begin
        if (acc) begin
          beats_left_d = beats_left_q - BC_ONE;
          if (beats_left_q <= BC_ONE) begin
            state_d      = ARB_IDLE;
            beats_left_d = '0;
            rr_ptr_d     = next_id(owner_q);
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      beats_left_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
      err_q        <= err_d;
    end
  end

  assign err_burst0     = err_q;
  assign dbg_state      = state_q;
  assign dbg_rr_ptr     = rr_ptr_q;
  assign dbg_beats_left = beats_left_q;

endmodule
